// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, least significant digit first.
// Subtraction adds the nines complement of B with an inverted borrow as the carry-in.
module bcd_serial_addsub #(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*N_DIGITS-1:0] a,
    input  logic [4*N_DIGITS-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] result,
    output logic                  cout,
    output logic                  invalid
);

    localparam int W     = 4 * N_DIGITS;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bad_q, bad_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q, cout_d;
    logic             invalid_q, invalid_d;

    logic             accept;
    logic             last_digit;
    logic [3:0]       a_dig, b_dig, b_eff, digit;
    logic [4:0]       sum;
    logic             carry_nx;
    logic             dig_bad, bad_all;
    logic [W-1:0]     result_shift;

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            bad_q     <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sub_q     <= sub_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            bad_q     <= bad_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
        end
    end

    assign accept     = start && (state_q != S_RUN);
    assign last_digit = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_digit) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operands shift right so the current digit is always the low nibble;
    // result digits enter at the top and land in place after N_DIGITS shifts.
    always_comb begin
        a_dig    = a_q[3:0];
        b_dig    = b_q[3:0];
        b_eff    = sub_q ? (4'd9 - b_dig) : b_dig;
        sum      = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
        dig_bad  = (a_dig > 4'd9) || (b_dig > 4'd9);
        bad_all  = bad_q || dig_bad;
        if (sum > 5'd9) begin
            digit    = sum[3:0] + 4'd6;
            carry_nx = 1'b1;
        end else begin
            digit    = sum[3:0];
            carry_nx = 1'b0;
        end
        result_shift = (result_q >> 4) | (W'(digit) << (W - 4));
    end

    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        bad_d     = bad_q;
        result_d  = result_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;
        if (accept) begin
            a_d       = a;
            b_d       = b;
            sub_d     = sub;
            carry_d   = sub ? ~cin : cin;
            idx_d     = '0;
            bad_d     = 1'b0;
            cout_d    = 1'b0;
            invalid_d = 1'b0;
        end else if (state_q == S_RUN) begin
            a_d      = a_q >> 4;
            b_d      = b_q >> 4;
            carry_d  = carry_nx;
            idx_d    = idx_q + 1'b1;
            bad_d    = bad_all;
            result_d = result_shift;
            if (last_digit) begin
                result_d  = bad_all ? '0 : result_shift;
                cout_d    = bad_all ? 1'b0 : carry_nx;
                invalid_d = bad_all;
            end
        end
    end

    always_comb begin
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        result  = result_q;
        cout    = cout_q;
        invalid = invalid_q;
    end

endmodule
